// File: rtl/bitty_wb_loader.sv
// bitty_wb_loader
//   Wishbone classic slave that streams instruction words from the management
//   SoC into the bitty core and captures the core's results for the host.
//
//   Register window (16 bytes at BASE_ADDR, decoded on wbs_adr_i[31:4]):
//     0x0 DATA   (W)  push wbs_dat_i[IW-1:0] into the instruction FIFO
//     0x4 STATUS (R)  {count[15:8], irq_en, res_overrun, result_valid,
//                      overflow, full, empty}
//     0x8 RESULT (R)  result register, zero-extended; clears result_valid
//     0xC CTRL   (RW) bit0 flush, bit1 clear sticky flags, bit2 irq_en
//
//   Ports:
//     wb_clk_i, wb_rst_ni          clock, synchronous active-low reset
//     wbs_cyc_i/stb_i/we_i/adr_i/dat_i/sel_i, wbs_ack_o/dat_o   Wishbone slave
//     instr_o, instr_valid_o, instr_ready_i    FIFO head to the core
//     res_i, res_valid_i                       result strobe from the core
//     irq_o                                    result_valid & irq_en, registered
module bitty_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8,
    parameter int          IW        = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [3:0]    wbs_sel_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [IW-1:0] instr_o,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    input  logic [IW-1:0] res_i,
    input  logic          res_valid_i,
    output logic          irq_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          rv_q, rv_d;
    logic          rovr_q, rovr_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
    logic [IW-1:0] res_q, res_d;
    logic [IW-1:0] mem_q [DEPTH];

    logic          in_win, new_req, bus_wr, bus_rd;
    logic [1:0]    reg_sel;
    logic          empty, full, push_req, push, pop;
    logic          ctrl_wr, flush, clr_flags, res_rd;
    logic [31:0]   status;

    // Byte-lane selects and the low address/data bits carry no information here.
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    assign in_win  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // ack_q gates the request so each access takes effect exactly once.
    assign new_req = wbs_cyc_i & wbs_stb_i & in_win & ~ack_q;
    assign bus_wr  = new_req & wbs_we_i;
    assign bus_rd  = new_req & ~wbs_we_i;
    assign reg_sel = wbs_adr_i[3:2];

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == FULL_CNT);
    assign push_req  = bus_wr & (reg_sel == 2'd0);
    // Fullness is judged on the pre-edge count, so a same-cycle pop does not
    // rescue a write to a full FIFO.
    assign push      = push_req & ~full;
    assign pop       = ~empty & instr_ready_i;
    assign ctrl_wr   = bus_wr & (reg_sel == 2'd3);
    assign flush     = ctrl_wr & wbs_dat_i[0];
    assign clr_flags = ctrl_wr & wbs_dat_i[1];
    assign res_rd    = bus_rd & (reg_sel == 2'd2);

    assign status = {16'b0, 8'(cnt_q), 2'b0, irq_en_q, rovr_q, rv_q, ovf_q, full, empty};

    always_comb begin
        ack_d    = new_req;
        dat_d    = '0;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        rv_d     = rv_q;
        rovr_d   = rovr_q;
        res_d    = res_q;
        irq_en_d = irq_en_q;
        irq_d    = rv_q & irq_en_q;

        if (bus_rd) begin
            case (reg_sel)
                2'd1:    dat_d = status;
                2'd2:    dat_d = 32'(res_q);
                2'd3:    dat_d = {29'b0, irq_en_q, 2'b0};
                default: dat_d = '0;
            endcase
        end

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        if (clr_flags) begin
            ovf_d  = 1'b0;
            rovr_d = 1'b0;
        end
        if (push_req & full) ovf_d = 1'b1;

        if (ctrl_wr) irq_en_d = wbs_dat_i[2];

        // A new result wins over a same-cycle RESULT read: the read returns
        // the old value and the fresh one stays pending, not an overrun.
        if (res_valid_i) begin
            res_d = res_i;
            rv_d  = 1'b1;
            if (rv_q & ~res_rd) rovr_d = 1'b1;
        end else if (res_rd) begin
            rv_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            rv_q     <= 1'b0;
            rovr_q   <= 1'b0;
            res_q    <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            rv_q     <= rv_d;
            rovr_q   <= rovr_d;
            res_q    <= res_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    // Storage needs no reset; the count decides what is visible.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wptr_q] <= wbs_dat_i[IW-1:0];
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;
    assign instr_valid_o = ~empty;
    assign instr_o       = empty ? '0 : mem_q[rptr_q];
    assign irq_o         = irq_q;

endmodule
